sn_window_decoder: RTL and testbench

SN_WINDOW_DECODER -- requirements
Module: sn_window_decoder

---
 rtl/sn_window_decoder.sv | 156 +++++++++++++++
 tb/tb_sn_window_decoder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sn_window_decoder.sv
// Stochastic-number window decoder.
// Counts the ones in a window of N = 2^win_sel valid bitstream samples and
// presents the count plus its bipolar value (2*ones - N) to a downstream
// consumer. Windows run back to back while en is high, with no dropped samples.
//
// Output handshake: out_valid rises on the edge after a window completes and
// stays high until an edge where out_ready=1 and no new window completes. A
// completion while a result is still held overwrites that result. If
// out_ready=0 on that edge, the overwrite sets the sticky overrun flag.
// busy mirrors the FSM state (1 = ACCUM) for observation.
module sn_window_decoder #(
    parameter int MAX_LOG2 = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       sn_bit,
    input  logic                       sn_valid,
    input  logic [3:0]                 win_sel,
    input  logic                       out_ready,
    input  logic                       clr_ovr,
    output logic [MAX_LOG2:0]          ones_cnt,
    output logic signed [MAX_LOG2+1:0] bip_val,
    output logic                       out_valid,
    output logic                       overrun,
    output logic                       busy
);

    localparam int CW = MAX_LOG2 + 1;
    localparam int BW = MAX_LOG2 + 2;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [3:0]      win_clamped;
    logic [3:0]      n_log2_q;
    logic [CW-1:0]   n_val;
    logic [CW-1:0]   bit_cnt_q;
    logic [CW-1:0]   ones_q;
    logic [CW-1:0]   bit_cnt_inc;
    logic [CW-1:0]   ones_inc;
    logic [BW-1:0]   bip_next;
    logic            start;
    logic            take_bit;
    logic            complete;

    // Clamp the requested window size into the supported range 3..MAX_LOG2.
    always_comb begin
        win_clamped = win_sel;
        if (win_sel < 4'd3) begin
            win_clamped = 4'd3;
        end else if (win_sel > 4'(MAX_LOG2)) begin
            win_clamped = 4'(MAX_LOG2);
        end
    end

    // Window length, counter increments and the bipolar value of the
    // window that would complete on this cycle.
    always_comb begin
        n_val       = {{(CW-1){1'b0}}, 1'b1} << n_log2_q;
        bit_cnt_inc = bit_cnt_q + {{(CW-1){1'b0}}, 1'b1};
        ones_inc    = ones_q + {{(CW-1){1'b0}}, sn_bit};
        bip_next    = {ones_inc, 1'b0} - {1'b0, n_val};
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        take_bit = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = ACCUM;
                    start   = 1'b1;
                end
            end
            ACCUM: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (sn_valid) begin
                    take_bit = 1'b1;
                    complete = (bit_cnt_inc == n_val);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Window counters; cleared on completion and whenever we are (or are
    // about to be) idle, so a dropped en discards the partial window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
            ones_q    <= '0;
        end else if (complete || state_d == IDLE) begin
            bit_cnt_q <= '0;
            ones_q    <= '0;
        end else if (take_bit) begin
            bit_cnt_q <= bit_cnt_inc;
            ones_q    <= ones_inc;
        end
    end

    // Window length is sampled only at the start of each window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_log2_q <= 4'd3;
        end else if (start || complete) begin
            n_log2_q <= win_clamped;
        end
    end

    // Result registers and output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_cnt  <= '0;
            bip_val   <= '0;
            out_valid <= 1'b0;
        end else if (complete) begin
            ones_cnt  <= ones_inc;
            bip_val   <= bip_next;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overrun: an unaccepted result was overwritten. Set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (complete && out_valid && !out_ready) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

    assign busy = (state_q == ACCUM);

endmodule

// File: tb/tb_sn_window_decoder.sv
// Directed and random stimulus for sn_window_decoder, checked against a
// behavioural window model whose completed results go through an expected queue.
module tb_sn_window_decoder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       sn_bit;
    logic       sn_valid;
    logic [3:0] win_sel;
    logic       out_ready;
    logic       clr_ovr;
    logic [8:0] ones_cnt;
    logic [9:0] bip_val;
    logic       out_valid;
    logic       overrun;
    logic       busy;

    int n_assert;
    int n_fail;

    // Reference model state.
    bit          m_accum;
    int          m_n;
    int          m_cnt;
    int          m_ones;
    bit          m_ov;
    bit          m_ovr;
    logic [8:0]  h_ones;
    logic [9:0]  h_bip;
    logic [18:0] exp_q[$];

    sn_window_decoder #(.MAX_LOG2(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sn_bit    (sn_bit),
        .sn_valid  (sn_valid),
        .win_sel   (win_sel),
        .out_ready (out_ready),
        .clr_ovr   (clr_ovr),
        .ones_cnt  (ones_cnt),
        .bip_val   (bip_val),
        .out_valid (out_valid),
        .overrun   (overrun),
        .busy      (busy)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clamp(input logic [3:0] w);
        if (w < 4'd3) return 3;
        if (w > 4'd8) return 8;
        return int'(w);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_accum = 0;
        m_n     = 8;
        m_cnt   = 0;
        m_ones  = 0;
        m_ov    = 0;
        m_ovr   = 0;
        h_ones  = '0;
        h_bip   = '0;
        exp_q.delete();
    endtask

    // One clock with the currently driven inputs; updates the model,
    // then checks every output #1 after the edge.
    task automatic tick();
        bit          comp;
        logic [18:0] e;
        comp = 0;
        if (!m_accum) begin
            if (en) begin
                m_accum = 1;
                m_n     = 1 << clamp(win_sel);
                m_cnt   = 0;
                m_ones  = 0;
            end
        end else if (!en) begin
            m_accum = 0;
            m_cnt   = 0;
            m_ones  = 0;
        end else if (sn_valid) begin
            m_cnt++;
            m_ones += int'(sn_bit);
            if (m_cnt == m_n) begin
                exp_q.push_back({9'(m_ones), 10'(2 * m_ones - m_n)});
                comp   = 1;
                m_cnt  = 0;
                m_ones = 0;
                m_n    = 1 << clamp(win_sel);
            end
        end
        if (comp && m_ov && !out_ready) m_ovr = 1;
        else if (clr_ovr) m_ovr = 0;
        if (comp) m_ov = 1;
        else if (out_ready) m_ov = 0;

        @(posedge clk);
        #1;
        if (comp) begin
            e      = exp_q.pop_front();
            h_ones = e[18:10];
            h_bip  = e[9:0];
        end
        chk("ones_cnt", 32'(ones_cnt), 32'(h_ones));
        chk("bip_val", 32'(bip_val), 32'(h_bip));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("busy", 32'(busy), 32'(m_accum));
    endtask

    // Send n valid bits, LSB of pat first.
    task automatic send_bits(input logic [31:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            sn_valid = 1'b1;
            sn_bit   = pat[i];
            tick();
        end
        sn_valid = 1'b0;
        sn_bit   = 1'b0;
    endtask

    task automatic send_rand(input int n);
        for (int i = 0; i < n; i++) begin
            sn_valid = 1'b1;
            sn_bit   = 1'($urandom_range(0, 1));
            tick();
        end
        sn_valid = 1'b0;
    endtask

    task automatic restart(input logic [3:0] ws);
        en = 1'b0;
        tick();
        win_sel = ws;
        en = 1'b1;
        tick();
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_ones", 32'(ones_cnt), 32'd0);
        chk("rst_bip", 32'(bip_val), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_valid", 32'(out_valid), 32'd0);
        chk("rst_hold_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        sn_bit    = 1'b0;
        sn_valid  = 1'b0;
        win_sel   = 4'd3;
        out_ready = 1'b0;
        clr_ovr   = 1'b0;
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ones", 32'(ones_cnt), 32'd0);
        chk("reset_bip", 32'(bip_val), 32'd0);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic 8-bit window: 1,0,1,1,0,0,1,0.
        en = 1'b1;
        tick();
        send_bits(32'h4D, 8);
        chk("w8_ones", 32'(ones_cnt), 32'd4);
        chk("w8_bip", 32'(bip_val), 32'd0);
        chk("w8_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("w8_accepted", 32'(out_valid), 32'd0);

        // win_sel=0 clamps to 8; all ones then all zeros.
        win_sel = 4'd0;
        send_bits(32'hFF, 8);
        chk("ones_all_cnt", 32'(ones_cnt), 32'd8);
        chk("ones_all_bip", 32'(bip_val), 32'd8);
        send_bits(32'hFF, 8);
        send_bits(32'h00, 8);
        chk("zeros_cnt", 32'(ones_cnt), 32'd0);
        chk("zeros_bip", 32'(bip_val), 32'h3F8);

        // 16-bit window with sn_valid toggling; mid-window win_sel change ignored.
        restart(4'd4);
        for (int i = 0; i < 32; i++) begin
            sn_valid = (i % 2 == 0);
            sn_bit   = 1'($urandom_range(0, 1));
            if (i == 10) win_sel = 4'd8;
            tick();
            if (i == 29) chk("w16_not_early", 32'(out_valid), 32'd0);
            if (i == 30) chk("w16_done", 32'(out_valid), 32'd1);
        end
        sn_valid = 1'b0;

        // Overrun across two unaccepted completions, then clear; set wins.
        out_ready = 1'b0;
        restart(4'd3);
        send_rand(16);
        chk("ovr_set", 32'(overrun), 32'd1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("ovr_clear", 32'(overrun), 32'd0);
        chk("ovr_valid_kept", 32'(out_valid), 32'd1);
        send_rand(7);
        clr_ovr  = 1'b1;
        sn_valid = 1'b1;
        sn_bit   = 1'b1;
        tick();
        chk("ovr_set_wins", 32'(overrun), 32'd1);
        sn_valid = 1'b0;
        tick();
        clr_ovr = 1'b0;

        // Partial window discarded when en drops.
        out_ready = 1'b1;
        tick();
        send_bits(32'h1F, 5);
        en       = 1'b0;
        sn_valid = 1'b1;
        sn_bit   = 1'b1;
        tick();
        chk("partial_no_result", 32'(out_valid), 32'd0);
        sn_valid = 1'b0;
        en = 1'b1;
        tick();
        send_bits(32'h0F, 8);
        chk("reentry_ones", 32'(ones_cnt), 32'd4);
        chk("reentry_valid", 32'(out_valid), 32'd1);

        // Reset mid-window while a result is held.
        out_ready = 1'b0;
        send_rand(8);
        send_rand(3);
        async_reset();
        en = 1'b0;
        tick();
        tick();
        en = 1'b1;
        tick();
        send_bits(32'hFF, 7);
        chk("post_rst_no_early", 32'(out_valid), 32'd0);
        send_bits(32'h1, 1);
        chk("post_rst_ones", 32'(ones_cnt), 32'd8);

        // Largest window: win_sel above MAX_LOG2, all ones.
        out_ready = 1'b1;
        restart(4'd15);
        for (int i = 0; i < 256; i++) begin
            sn_valid = 1'b1;
            sn_bit   = 1'b1;
            tick();
        end
        sn_valid = 1'b0;
        chk("max_ones", 32'(ones_cnt), 32'd256);
        chk("max_bip", 32'(bip_val), 32'h100);

        // Random traffic.
        restart(4'd3);
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 39) != 0);
            sn_valid  = 1'($urandom_range(0, 1));
            sn_bit    = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            clr_ovr   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) win_sel = 4'($urandom_range(0, 5));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
